// File: rtl/dff_trace_recorder_if.sv
`default_nettype none
// ============================================================================
// Module   : dff_trace_recorder_if
// Brief    : Record drain port of the DFF trace recorder. The recorder
//            presents records as master and the consumer accepts as slave.
// Revision : 1.0 - initial release
// ============================================================================
interface dff_trace_recorder_if #(
    parameter int DEPTH = 8,
    parameter int TS_W  = 8
);
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    logic                 out_valid;
    logic                 out_ready;
    logic [TS_W+3:0]      out_data;
    logic [c_cnt_w-1:0]   count;
    logic                 overflow;

    modport master (
        output out_valid,
        output out_data,
        output count,
        output overflow,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  count,
        input  overflow,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/dff_trace_recorder.sv
`default_nettype none
// ============================================================================
// Module   : dff_trace_recorder
// Brief    : Samples {Y,Z,S,R} each clock, stores every change as a
//            timestamped record in a FWFT FIFO drained over valid/ready.
//            Optional TRACE_OVF_CNT_EN adds a saturating dropped-record count.
// Revision : 1.0 - initial release
// ============================================================================
module dff_trace_recorder #(
    parameter int DEPTH = 8,
    parameter int TS_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en,
    input  logic                  y,
    input  logic                  z,
    input  logic                  s,
    input  logic                  r,
    dff_trace_recorder_if.master  trc
`ifdef TRACE_OVF_CNT_EN
    ,
    output logic [7:0]            ovf_cnt
`endif
);

    localparam int c_aw    = $clog2(DEPTH);
    localparam int c_cnt_w = c_aw + 1;
    localparam int c_rec_w = TS_W + 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [TS_W-1:0]      r_ts;
    logic [TS_W-1:0]      w_ts_nxt;

    logic [3:0]           r_smp;
    logic [3:0]           r_prev;
    logic                 w_chg;

    logic                 w_push_req;
    logic [c_rec_w-1:0]   w_push_rec;

    logic [c_rec_w-1:0]   r_mem [DEPTH];
    logic [c_aw-1:0]      r_wr_ptr;
    logic [c_aw-1:0]      r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;
    logic                 r_overflow;

    logic                 w_valid;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;

    // ------------------------------------------------------------------
    // Input sampling and change detection
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_smp  <= 4'b0000;
            r_prev <= 4'b0000;
        end else begin
            r_smp  <= {y, z, s, r};
            r_prev <= r_smp;
        end
    end

    assign w_chg = (r_smp != r_prev);

    // ------------------------------------------------------------------
    // Recording FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ts    <= '0;
        end else if (clr) begin
            r_state <= ST_IDLE;
            r_ts    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ts    <= w_ts_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ts_nxt    = r_ts;
        w_push_req  = 1'b0;
        w_push_rec  = {r_ts, r_smp};
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_state_nxt = ST_ARM;
                end
            end
            ST_ARM: begin
                // Baseline snapshot is stamped zero; the first RUN cycle is 1.
                w_push_req  = 1'b1;
                w_push_rec  = {{TS_W{1'b0}}, r_smp};
                w_ts_nxt    = TS_W'(1);
                w_state_nxt = en ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                w_ts_nxt = r_ts + TS_W'(1);
                if (!en) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_chg) begin
                    w_push_req = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Record FIFO
    // ------------------------------------------------------------------
    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == c_cnt_w'(DEPTH));
    assign w_pop   = w_valid && trc.out_ready && !clr;
    assign w_push  = w_push_req && !clr && (!w_full || w_pop);
    assign w_drop  = w_push_req && !clr && w_full && !w_pop;

    // When full with a simultaneous pop the write lands in the slot being vacated.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_rec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (clr) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef TRACE_OVF_CNT_EN
    logic [7:0] r_ovf_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_cnt <= 8'd0;
        end else if (clr) begin
            r_ovf_cnt <= 8'd0;
        end else if (w_drop && (r_ovf_cnt != 8'hFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 8'd1;
        end
    end

    assign ovf_cnt = r_ovf_cnt;
`endif

    // Empty FIFO presents zero so the head is zero out of reset.
    assign trc.out_valid = w_valid;
    assign trc.out_data  = w_valid ? r_mem[r_rd_ptr] : '0;
    assign trc.count     = r_count;
    assign trc.overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_dff_trace_recorder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dff_trace_recorder
// Brief    : Randomised scoreboard bench for dff_trace_recorder with a
//            behavioural reference model of the recording rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dff_trace_recorder;

    localparam int DEPTH = 8;
    localparam int TS_W  = 8;
    localparam int M_IDLE = 0;
    localparam int M_ARM  = 1;
    localparam int M_RUN  = 2;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       en;
    logic [3:0] vin;
    logic       ready;

    int n_tests = 0;
    int n_fail  = 0;

    dff_trace_recorder_if #(.DEPTH(DEPTH), .TS_W(TS_W)) trc ();
    assign trc.out_ready = ready;

`ifdef TRACE_OVF_CNT_EN
    logic [7:0] ovf_cnt;
`endif

    dff_trace_recorder #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (en),
        .y     (vin[3]),
        .z     (vin[2]),
        .s     (vin[1]),
        .r     (vin[0]),
        .trc   (trc)
`ifdef TRACE_OVF_CNT_EN
        ,
        .ovf_cnt (ovf_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: expected records (oldest first) and occupancy
    int sb[$];
    int m_cnt     = 0;
    int m_ovf     = 0;
    int m_ovf_cnt = 0;
    int m_mode    = M_IDLE;
    int m_ts      = 0;
    int m_smp     = 0;
    int m_prev    = 0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                sb.delete();
                m_cnt = 0; m_ovf = 0; m_ovf_cnt = 0;
                m_mode = M_IDLE; m_ts = 0; m_smp = 0; m_prev = 0;
            end else begin
                bit want;
                bit popping;
                int rec;
                want    = 0;
                rec     = 0;
                popping = (m_cnt > 0) && ready && !clr;
                if (clr) begin
                    sb.delete();
                    m_cnt = 0; m_ovf = 0; m_ovf_cnt = 0;
                    m_ts = 0; m_mode = M_IDLE;
                end else begin
                    if (m_mode == M_IDLE) begin
                        if (en) m_mode = M_ARM;
                    end else if (m_mode == M_ARM) begin
                        want   = 1;
                        rec    = m_smp;
                        m_ts   = 1;
                        m_mode = en ? M_RUN : M_IDLE;
                    end else begin
                        if (!en) begin
                            m_mode = M_IDLE;
                        end else if (m_smp != m_prev) begin
                            want = 1;
                            rec  = m_ts * 16 + m_smp;
                        end
                        m_ts = (m_ts + 1) % (1 << TS_W);
                    end
                    if (want) begin
                        if (m_cnt < DEPTH || popping) begin
                            sb.push_back(rec);
                            m_cnt++;
                        end else begin
                            m_ovf = 1;
                            if (m_ovf_cnt < 255) m_ovf_cnt++;
                        end
                    end
                    if (popping) m_cnt--;
                end
                m_prev = m_smp;
                m_smp  = int'(vin);
            end
        end
    end

    // Monitor: compare status every cycle and the head record on each handshake
    initial begin
        forever begin
            @(negedge clk);
            check("count",    32'(trc.count),     m_cnt);
            check("valid",    32'(trc.out_valid), 32'(m_cnt != 0));
            check("overflow", 32'(trc.overflow),  m_ovf);
`ifdef TRACE_OVF_CNT_EN
            check("ovf_cnt",  32'(ovf_cnt),       m_ovf_cnt);
`endif
            if (trc.out_valid) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL head_data: got 0x%0h, expected no record at %0t", trc.out_data, $time);
                end else begin
                    check("head_data", 32'(trc.out_data), sb[0]);
                    if (ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        int rp;
        rst_n = 1'b0; clr = 1'b0; en = 1'b0; vin = 4'b0000; ready = 1'b0;
        repeat (3) tick();
        check("rst_valid", 32'(trc.out_valid), 0);
        check("rst_data",  32'(trc.out_data),  0);
        check("rst_count", 32'(trc.count),     0);
        check("rst_ovf",   32'(trc.overflow),  0);
        rst_n = 1'b1;
        tick();

        // Baseline record appears two edges after EN
        en = 1'b1;
        tick();
        check("arm_count", 32'(trc.count), 0);
        tick();
        check("base_valid", 32'(trc.out_valid), 1);
        check("base_count", 32'(trc.count),     1);
        check("base_data",  32'(trc.out_data),  0);

        // 0000 -> 1010 -> 1010 -> 0101: two records only
        vin = 4'b1010; tick(); tick();
        vin = 4'b0101; tick(); tick();
        tick();
        check("seq_count", 32'(trc.count), 3);

        // Overfill with Y toggling every cycle
        for (int i = 0; i < DEPTH + 3; i++) begin
            vin[3] = ~vin[3];
            tick();
        end
        tick(); tick();
        check("full_count", 32'(trc.count),    DEPTH);
        check("ovf_set",    32'(trc.overflow), 1);
        ready = 1'b1;
        repeat (DEPTH + 4) tick();
        check("drain_count", 32'(trc.count),    0);
        check("ovf_sticky",  32'(trc.overflow), 1);

        // Full FIFO with push and pop on the same edge
        ready = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
        check("clr_count", 32'(trc.count),    0);
        check("clr_ovf",   32'(trc.overflow), 0);
        tick(); tick();
        for (int i = 0; i < DEPTH - 1; i++) begin
            vin[2] = ~vin[2];
            tick();
        end
        tick();
        check("fill_count", 32'(trc.count),    DEPTH);
        check("fill_ovf",   32'(trc.overflow), 0);
        vin[2] = ~vin[2]; tick();
        ready = 1'b1; tick(); ready = 1'b0;
        check("swap_count", 32'(trc.count),    DEPTH);
        check("swap_ovf",   32'(trc.overflow), 0);
        ready = 1'b1;
        repeat (DEPTH + 4) tick();

        // Timestamp wrap: a change every 100 cycles
        for (int i = 0; i < 320; i++) begin
            if (i % 100 == 0) vin[0] = ~vin[0];
            tick();
        end

        // Randomised traffic with varying backpressure and occasional clears
        for (int blk = 0; blk < 15; blk++) begin
            rp = (blk % 3 == 0) ? 10 : ((blk % 3 == 1) ? 50 : 90);
            for (int i = 0; i < 100; i++) begin
                en    = ($urandom_range(0, 15) != 0);
                clr   = ($urandom_range(0, 99) == 0);
                ready = ($urandom_range(0, 99) < rp);
                if ($urandom_range(0, 2) == 0) vin = 4'($urandom_range(0, 15));
                tick();
            end
        end
        clr = 1'b0;

        // CLR with five records stored, then confirm IDLE
        ready = 1'b0; en = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
        en = 1'b1; tick(); tick();
        for (int i = 0; i < 4; i++) begin
            vin[1] = ~vin[1];
            tick();
        end
        tick();
        check("five_count", 32'(trc.count), 5);
        en = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
        check("clr5_count", 32'(trc.count),     0);
        check("clr5_valid", 32'(trc.out_valid), 0);
        check("clr5_ovf",   32'(trc.overflow),  0);
        vin[1] = ~vin[1];
        repeat (3) tick();
        check("idle_count", 32'(trc.count), 0);

        // Asynchronous reset in the middle of a drain
        en = 1'b1; tick(); tick();
        for (int i = 0; i < 3; i++) begin
            vin[0] = ~vin[0];
            tick();
        end
        tick();
        ready = 1'b1; tick();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(trc.out_valid), 0);
        check("arst_data",  32'(trc.out_data),  0);
        check("arst_count", 32'(trc.count),     0);
        check("arst_ovf",   32'(trc.overflow),  0);
        ready = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
